// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith ops, iterative shifts and multiply.
// Latency: ops 0-4 complete on the accepting edge, shifts after max(n,1) edges, MUL after WIDTH edges.
// Backpressure: Busy high while an iterative op runs; Start is ignored (not queued) until IDLE.
module alu_exec_unit #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     RegOutA,
  input  logic [WIDTH-1:0]     RegOutB,
  input  logic [IMM_WIDTH-1:0] Imm,
  input  logic [1:0]           ALUSrcB,
  input  logic [2:0]           AluOp,
  input  logic                 Start,
  input  logic                 ALUOutWrite,
  output logic                 Busy,
  output logic                 Done,
  output logic [WIDTH-1:0]     ALUOutData,
  output logic                 ovfl,
  output logic                 Zero
);

  // Shift amount width and iteration counter width (counter must hold WIDTH for MUL).
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched operation context for the iterative ops.
  logic [WIDTH-1:0] r_a;     // shift working value, or MUL multiplicand
  logic [WIDTH-1:0] r_b;     // MUL: low half of product / remaining multiplier bits
  logic [WIDTH-1:0] r_hi;    // MUL: high half of partial product
  logic [2:0]       r_op;
  logic             r_wr;
  logic [CW-1:0]    r_cnt;

  // Architectural outputs.
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_ovfl;

  // Operand-B path.
  logic [WIDTH-1:0] w_imm_z;
  logic [WIDTH-1:0] w_imm_s;
  logic [WIDTH-1:0] w_imm_s1;
  logic [WIDTH-1:0] w_opb;

  // Single-cycle datapath.
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_lt;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_ovfl;
  logic             w_multi;

  // Iterative datapath.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_shift;
  logic             w_run_last;
  logic [WIDTH-1:0] w_run_res;
  logic             w_run_ovfl;

  // FSM decisions.
  logic             w_load;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_wr_ovfl;
  logic             w_done_nxt;

  assign w_imm_z  = {{(WIDTH-IMM_WIDTH){1'b0}}, Imm};
  assign w_imm_s  = {{(WIDTH-IMM_WIDTH){Imm[IMM_WIDTH-1]}}, Imm};
  assign w_imm_s1 = {w_imm_s[WIDTH-2:0], 1'b0};

  // Operand-B select: register, zero/sign-extended immediate, or sign-extended immediate << 1.
  always_comb begin
    w_opb = RegOutB;
    case (ALUSrcB)
      2'd0:    w_opb = RegOutB;
      2'd1:    w_opb = w_imm_z;
      2'd2:    w_opb = w_imm_s;
      2'd3:    w_opb = w_imm_s1;
      default: w_opb = RegOutB;
    endcase
  end

  assign w_add   = RegOutA + w_opb;
  assign w_sub   = RegOutA - w_opb;
  assign w_lt    = $signed(RegOutA) < $signed(w_opb);
  assign w_multi = (AluOp == OP_SLL) || (AluOp == OP_SRA) || (AluOp == OP_MUL);

  // Single-cycle result and signed-overflow flag; overflow when operand signs make the result sign impossible.
  always_comb begin
    w_sc_res  = '0;
    w_sc_ovfl = 1'b0;
    case (AluOp)
      OP_AND: w_sc_res = RegOutA & w_opb;
      OP_OR:  w_sc_res = RegOutA | w_opb;
      OP_ADD: begin
        w_sc_res  = w_add;
        w_sc_ovfl = (RegOutA[WIDTH-1] == w_opb[WIDTH-1]) &&
                    (w_add[WIDTH-1] != RegOutA[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res  = w_sub;
        w_sc_ovfl = (RegOutA[WIDTH-1] != w_opb[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != RegOutA[WIDTH-1]);
      end
      OP_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: begin
        w_sc_res  = '0;
        w_sc_ovfl = 1'b0;
      end
    endcase
  end

  // One iteration step: shift-add multiply retires one multiplier bit, shifts move one bit position.
  always_comb begin
    w_sum      = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : '0);
    w_shift    = (r_op == OP_SRA) ? {r_a[WIDTH-1], r_a[WIDTH-1:1]}
                                  : {r_a[WIDTH-2:0], 1'b0};
    w_run_last = (r_cnt <= CW'(1));
    w_run_res  = r_a;
    w_run_ovfl = 1'b0;
    if (r_op == OP_MUL) begin
      // Final step: product = {hi, lo}; anything left in hi means it did not fit.
      w_run_res  = {w_sum[0], r_b[WIDTH-1:1]};
      w_run_ovfl = |w_sum[WIDTH:1];
    end else begin
      // A zero shift amount still takes one cycle and returns A untouched.
      w_run_res  = (r_cnt == '0) ? r_a : w_shift;
      w_run_ovfl = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and control: accept in IDLE, finish iterative ops in RUN.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_data    = w_sc_res;
    w_wr_ovfl    = w_sc_ovfl;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (w_multi) begin
            w_next_state = S_RUN;
            w_load       = 1'b1;
          end else begin
            w_wr_en    = ALUOutWrite;
            w_done_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Start is deliberately not looked at here: requests during a run are dropped.
        if (w_run_last) begin
          w_next_state = S_IDLE;
          w_wr_en      = r_wr;
          w_wr_data    = w_run_res;
          w_wr_ovfl    = w_run_ovfl;
          w_done_nxt   = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Iterative operand/context registers: latch on accept, step each RUN cycle until the last one.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_op  <= OP_AND;
      r_wr  <= 1'b0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_a   <= RegOutA;
      r_b   <= w_opb;
      r_hi  <= '0;
      r_op  <= AluOp;
      r_wr  <= ALUOutWrite;
      r_cnt <= (AluOp == OP_MUL) ? CW'(WIDTH) : {1'b0, w_opb[SW-1:0]};
    end else if ((r_state == S_RUN) && !w_run_last) begin
      if (r_op == OP_MUL) begin
        r_hi <= w_sum[WIDTH:1];
        r_b  <= {w_sum[0], r_b[WIDTH-1:1]};
      end else begin
        r_a <= w_shift;
      end
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Result, flag and completion pulse registers; result/flag hold when the write is disabled.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_done <= 1'b0;
      r_out  <= '0;
      r_ovfl <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_wr_en) begin
        r_out  <= w_wr_data;
        r_ovfl <= w_wr_ovfl;
      end
    end
  end

  assign Busy       = (r_state == S_RUN);
  assign Done       = r_done;
  assign ALUOutData = r_out;
  assign ovfl       = r_ovfl;
  assign Zero       = (r_out == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: randomized plus directed ops against an arithmetic reference model.
// Driver pushes expected {result, ovfl, completion edge}; monitor pops on each Done.
// Covers back-to-back issue, Start during a run, Write=0 holds, and async reset abort.
module tb_alu_exec_unit;
  localparam int W  = 16;
  localparam int IW = 8;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic [W-1:0]  RegOutA = '0;
  logic [W-1:0]  RegOutB = '0;
  logic [IW-1:0] Imm = '0;
  logic [1:0]    ALUSrcB = '0;
  logic [2:0]    AluOp = '0;
  logic          Start = 1'b0;
  logic          ALUOutWrite = 1'b0;
  logic          Busy, Done, ovfl, Zero;
  logic [W-1:0]  ALUOutData;

  alu_exec_unit #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .CLK(CLK), .Reset(Reset), .RegOutA(RegOutA), .RegOutB(RegOutB), .Imm(Imm),
    .ALUSrcB(ALUSrcB), .AluOp(AluOp), .Start(Start), .ALUOutWrite(ALUOutWrite),
    .Busy(Busy), .Done(Done), .ALUOutData(ALUOutData), .ovfl(ovfl), .Zero(Zero)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           edge_no;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  logic [W-1:0] model_out = '0;
  logic         model_ovfl = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!Reset && Done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_edge", 32'(cyc), 32'(e.edge_no));
        chk("result", 32'(ALUOutData), 32'(e.res));
        chk("ovfl", 32'(ovfl), 32'(e.ovf));
        chk("zero", 32'(Zero), 32'(e.res == '0));
        chk("busy_at_done", 32'(Busy), 32'd0);
      end
    end
  end

  // Issue one op (called #1 after a rising edge), wait out its run, optionally poke Start mid-run or abort by reset.
  task automatic issue(input logic [2:0] op, input logic [1:0] src, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [IW-1:0] imm, input logic wr,
                       input bit mid_start, input int abort_at);
    logic [W-1:0] opb, res;
    logic ovf;
    int s, sa, sb, r, n, lat, k;
    longint p;
    s = $signed(imm);
    case (src)
      2'd0: opb = b;
      2'd1: opb = {8'h00, imm};
      2'd2: opb = 16'(s);
      default: opb = 16'(s * 2);
    endcase
    sa = $signed(a);
    sb = $signed(opb);
    n = int'(opb) % W;
    ovf = 1'b0;
    lat = 0;
    res = '0;
    case (op)
      3'd0: res = a & opb;
      3'd1: res = a | opb;
      3'd2: begin r = sa + sb; res = 16'(r); ovf = (r > 32767) || (r < -32768); end
      3'd3: begin r = sa - sb; res = 16'(r); ovf = (r > 32767) || (r < -32768); end
      3'd4: res = (sa < sb) ? 16'd1 : 16'd0;
      3'd5: begin res = 16'(a << n); lat = (n == 0) ? 1 : n; end
      3'd6: begin res = 16'(sa >>> n); lat = (n == 0) ? 1 : n; end
      default: begin
        p = longint'(a) * longint'(opb);
        res = 16'(p);
        ovf = (p > 65535);
        lat = W;
      end
    endcase
    if (wr) begin
      model_out  = res;
      model_ovfl = ovf;
    end
    k = cyc + 1;
    exp_q.push_back('{res: model_out, ovf: model_ovfl, edge_no: k + lat});
    AluOp = op; ALUSrcB = src; RegOutA = a; RegOutB = b; Imm = imm; ALUOutWrite = wr; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    RegOutA = 16'($urandom); RegOutB = 16'($urandom); Imm = 8'($urandom);
    ALUSrcB = 2'($urandom); AluOp = 3'($urandom); ALUOutWrite = 1'($urandom);
    for (int i = 0; i < lat; i++) begin
      @(negedge CLK);
      chk("busy_during_run", 32'(Busy), 32'd1);
      if (i == abort_at) begin
        Reset = 1'b1;
        #1;
        chk("abort_data", 32'(ALUOutData), 32'd0);
        chk("abort_ovfl", 32'(ovfl), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_zero", 32'(Zero), 32'd1);
        void'(exp_q.pop_back());
        model_out  = '0;
        model_ovfl = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b0;
        return;
      end
      if (mid_start && i == 1) begin
        Start = 1'b1; AluOp = 3'd2; ALUOutWrite = 1'b1; RegOutA = 16'($urandom);
      end
      if (i == 2) Start = 1'b0;
      @(posedge CLK); #1;
    end
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    int gap;
    #2;
    chk("rst_data", 32'(ALUOutData), 32'd0);
    chk("rst_ovfl", 32'(ovfl), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;

    // Directed cases (first Start right after reset release).
    issue(3'd2, 2'd0, 16'd10, 16'd20, 8'd0, 1'b1, 0, -1);      // 30
    issue(3'd2, 2'd2, 16'd20, 16'd0, 8'd5, 1'b1, 0, -1);       // 25
    issue(3'd0, 2'd1, 16'hFFFF, 16'd0, 8'hFF, 1'b1, 0, -1);    // 00FF
    issue(3'd0, 2'd2, 16'hFFFF, 16'd0, 8'hFF, 1'b1, 0, -1);    // FFFF
    issue(3'd0, 2'd3, 16'hFFFF, 16'd0, 8'hFF, 1'b1, 0, -1);    // FFFE
    issue(3'd2, 2'd0, 16'h7FFF, 16'd1, 8'd0, 1'b1, 0, -1);     // 8000 ovfl
    issue(3'd3, 2'd0, 16'h8000, 16'd1, 8'd0, 1'b1, 0, -1);     // 7FFF ovfl
    issue(3'd3, 2'd0, 16'd5, 16'd5, 8'd0, 1'b1, 0, -1);        // 0 Zero
    issue(3'd4, 2'd0, 16'hFFF0, 16'd3, 8'd0, 1'b1, 0, -1);     // signed -16 < 3
    issue(3'd5, 2'd0, 16'd1, 16'd5, 8'd0, 1'b1, 1, -1);        // 0020, Start mid-run ignored
    issue(3'd6, 2'd0, 16'h8000, 16'd3, 8'd0, 1'b1, 0, -1);     // F000
    issue(3'd5, 2'd0, 16'h1234, 16'h0010, 8'd0, 1'b1, 0, -1);  // shift by 0 -> A at k+1
    issue(3'd7, 2'd0, 16'd300, 16'd300, 8'd0, 1'b1, 0, -1);    // 5F90 ovfl
    issue(3'd7, 2'd0, 16'd3, 16'd4, 8'd0, 1'b1, 0, -1);        // 12 back-to-back
    issue(3'd7, 2'd0, 16'd300, 16'd300, 8'd0, 1'b1, 0, 8);     // reset abort
    repeat (20) begin
      @(negedge CLK);
      chk("idle_after_abort", 32'(Busy), 32'd0);
    end
    @(posedge CLK); #1;
    issue(3'd2, 2'd0, 16'd7, 16'd8, 8'd0, 1'b1, 0, -1);        // 15
    issue(3'd2, 2'd0, 16'd1, 16'd1, 8'd0, 1'b0, 0, -1);        // Write=0 -> 15 held
    issue(3'd7, 2'd0, 16'd9, 16'd9, 8'd0, 1'b0, 0, -1);        // Write=0 multi-cycle

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      rop = 3'($urandom);
      issue(rop, 2'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) && (rop == 3'd7), -1);
      if ($urandom_range(0, 3) == 0) begin
        gap = $urandom_range(1, 3);
        repeat (gap) @(posedge CLK);
        #1;
      end
    end

    repeat (5) @(posedge CLK);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16: datapath width, ≥ 4.
REQ-002 Parameter IMM_WIDTH, default 8: immediate width, < WIDTH.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 RegOutA  input  WIDTH  operand A from register file.
REQ-006 RegOutB  input  WIDTH  operand B from register file.
REQ-007 Imm  input  IMM_WIDTH  instruction immediate.
REQ-008 ALUSrcB  input  2  operand-B select.
REQ-009 AluOp  input  3  operation select.
REQ-010 Start  input  1  request; sampled only in IDLE.
REQ-011 ALUOutWrite  input  1  result-write enable, sampled with Start.
REQ-012 Busy  output  1  high while a multi-cycle operation runs.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 ALUOutData  output  WIDTH  registered result.
REQ-015 ovfl  output  1  registered overflow flag.
REQ-016 Zero  output  1  high when ALUOutData == 0 (combinational from register).

Function
REQ-017 Operand B: ALUSrcB 0 = RegOutB; 1 = zero-extended Imm; 2 = sign-extended Imm; 3 = sign-extended Imm shifted left 1, MSB discarded.
REQ-018 AluOp: 0 AND, 1 OR, 2 ADD, 3 SUB (A−B), 4 SLT signed (result 1/0), 5 SLL, 6 SRA, 7 MUL (low WIDTH bits of unsigned product).
REQ-019 Ops 0-4 are single-cycle; ops 5-7 are multi-cycle, iterative (no barrel shifter, no array multiplier).
REQ-020 States IDLE and RUN only; Reset forces IDLE.
REQ-021 IDLE with Start=1 and single-cycle op at edge k: result and flags written at edge k; Done=1 during cycle k→k+1; Busy stays 0.
REQ-022 IDLE with Start=1 and multi-cycle op at edge k: A, muxed B, AluOp and ALUOutWrite latched; go to RUN; Busy=1 from edge k.
REQ-023 Shift amount = low $clog2(WIDTH) bits of latched B; one bit position per cycle; completes at edge k+max(n,1); amount 0 returns A unchanged at edge k+1.
REQ-024 SRA replicates sign bit; SLL fills zeros.
REQ-025 MUL: shift-add, one multiplier bit per cycle; completes at edge k+WIDTH.
REQ-026 Completion edge: result written (if latched ALUOutWrite=1), Done=1 for the following cycle, Busy=0, return to IDLE.
REQ-027 Start accepted in the cycle Done is high (back-to-back issue, no bubble).
REQ-028 Start while RUN: ignored, no effect on the running operation, not queued.
REQ-029 Latched ALUOutWrite=0: Done still pulses; ALUOutData and ovfl hold previous values.
REQ-030 ovfl: ADD/SUB signed two's-complement overflow; MUL = 1 if full unsigned product exceeds WIDTH bits; all other ops 0.
REQ-031 Operand inputs may change after the accepting edge without affecting a running operation.

Reset
REQ-032 Reset asserted: immediately ALUOutData=0, ovfl=0, Busy=0, Done=0, state IDLE, iteration counter and partial results cleared.
REQ-033 Reset during RUN aborts the operation; no Done and no write on release.
REQ-034 First Start is accepted on the first rising edge after Reset deasserts.

Verification (WIDTH=16, IMM_WIDTH=8)
REQ-035 A=10, RegOutB=20, ALUSrcB=0, ADD, Start, Write=1 -> ALUOutData=30, Done one cycle, Busy=0, ovfl=0; then A=20, Imm=5, ALUSrcB=2 -> 25.
REQ-036 A=0xFFFF, Imm=0xFF, AND, ALUSrcB=1/2/3 -> 0x00FF / 0xFFFF / 0xFFFE.
REQ-037 ADD 0x7FFF+1 -> 0x8000, ovfl=1; SUB 0x8000−1 -> 0x7FFF, ovfl=1; SUB 5−5 -> 0, Zero=1.
REQ-038 SLL A=1, B=5 -> Busy for 5 cycles, 0x0020 at edge k+5; Start issued mid-run ignored; SRA 0x8000 by 3 -> 0xF000.
REQ-039 MUL 300×300 -> 0x5F90, ovfl=1, Done after edge k+16; immediate back-to-back MUL 3×4 -> 12, ovfl=0.
REQ-040 Reset at cycle 8 of MUL -> all outputs 0 asynchronously, no Done; run with Write=0 -> Done pulses, ALUOutData unchanged.
